// File: rtl/bus_term_if.sv
// bus_term_if: per-terminal bus interface placed on one port of the bus
// generator/arbiter.
//   TX: host_wr/host_wdata -> FIFO -> pndng/D_pop, advanced by the bus pop.
//   RX: push/D_push -> destination filter (id or broadcast) -> FIFO ->
//       rx_valid/host_rdata, advanced by host_rd.
//   tx_cnt/rx_cnt/tx_full report occupancy. tx_ovf/rx_ovf are sticky drop
//   flags, cleared by ovf_clr (a drop in the same cycle wins over the clear).
//   reset is asynchronous and active-low. Every output comes from registered
//   state, so there is no combinational path from any strobe to any output.

// Show-ahead circular FIFO. The occupancy count is kept separately from the
// pointers, so full and empty never alias. drop flags a write that was
// discarded because the FIFO was full and nothing was read in that cycle.
module bus_term_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [width-1:0]           wdata,
    input  logic                       rd,
    output logic [width-1:0]           head,
    output logic [$clog2(depth+1)-1:0] cnt,
    output logic                       full,
    output logic                       drop
);
    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             do_rd;
    logic             do_wr;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    // A read of an empty FIFO is ignored. A write to a full FIFO still lands
    // when a read frees the head slot in the same cycle.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign drop  = wr && full && !rd;
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // The pointers wrap from depth-1 to 0 naturally because depth
            // is a power of two.
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    // The storage needs no reset: head is forced to 0 whenever the FIFO is
    // empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wdata;
    end
endmodule

module bus_term_if #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_wr,
    input  logic [pckg_sz-1:0]         host_wdata,
    output logic                       tx_full,
    output logic [$clog2(depth+1)-1:0] tx_cnt,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    input  logic                       host_rd,
    output logic                       rx_valid,
    output logic [pckg_sz-1:0]         host_rdata,
    output logic [$clog2(depth+1)-1:0] rx_cnt,
    output logic                       tx_ovf,
    output logic                       rx_ovf,
    input  logic                       ovf_clr
);
    logic [7:0] dst;
    logic       rx_accept;
    logic       rx_full;
    logic       tx_drop;
    logic       rx_drop;

    bus_term_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (host_wr),
        .wdata (host_wdata),
        .rd    (pop),
        .head  (D_pop),
        .cnt   (tx_cnt),
        .full  (tx_full),
        .drop  (tx_drop)
    );

    // Only packets addressed to this terminal or to broadcast are written;
    // all other packets are discarded without a flag or a count change.
    assign dst       = D_push[pckg_sz-1 -: 8];
    assign rx_accept = push && ((dst == id) || (dst == broadcast));

    bus_term_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_accept),
        .wdata (D_push),
        .rd    (host_rd),
        .head  (host_rdata),
        .cnt   (rx_cnt),
        .full  (rx_full),
        .drop  (rx_drop)
    );

    assign pndng    = (tx_cnt != '0);
    assign rx_valid = (rx_cnt != '0);

    // A new drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= tx_drop || (tx_ovf && !ovf_clr);
            rx_ovf <= rx_drop || (rx_ovf && !ovf_clr);
        end
    end
endmodule

// File: tb/tb_bus_term_if.sv
module tb_bus_term_if;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          host_wr = 1'b0;
    logic [15:0]   host_wdata = '0;
    logic          tx_full;
    logic [CW-1:0] tx_cnt;
    logic          pndng;
    logic [15:0]   D_pop;
    logic          pop = 1'b0;
    logic          push = 1'b0;
    logic [15:0]   D_push = '0;
    logic          host_rd = 1'b0;
    logic          rx_valid;
    logic [15:0]   host_rdata;
    logic [CW-1:0] rx_cnt;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    bus_term_if #(.pckg_sz(16), .depth(DEPTH), .id(8'h01), .broadcast(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_wr    (host_wr),
        .host_wdata (host_wdata),
        .tx_full    (tx_full),
        .tx_cnt     (tx_cnt),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .push       (push),
        .D_push     (D_push),
        .host_rd    (host_rd),
        .rx_valid   (rx_valid),
        .host_rdata (host_rdata),
        .rx_cnt     (rx_cnt),
        .tx_ovf     (tx_ovf),
        .rx_ovf     (rx_ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two packet queues plus sticky flags.
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic        m_tx_ovf = 1'b0;
    logic        m_rx_ovf = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
        end else begin
            bit tx_pop, tx_ok, rx_pop, rx_ok, acc;
            tx_pop = pop && (txq.size() != 0);
            tx_ok  = host_wr && (txq.size() < DEPTH || tx_pop);
            if (tx_pop) void'(txq.pop_front());
            if (tx_ok) txq.push_back(host_wdata);
            acc    = push && (D_push[15:8] == 8'h01 || D_push[15:8] == 8'hFF);
            rx_pop = host_rd && (rxq.size() != 0);
            rx_ok  = acc && (rxq.size() < DEPTH || rx_pop);
            if (rx_pop) void'(rxq.pop_front());
            if (rx_ok) rxq.push_back(D_push);
            if (ovf_clr) begin
                m_tx_ovf = 1'b0;
                m_rx_ovf = 1'b0;
            end
            if (host_wr && !tx_ok) m_tx_ovf = 1'b1;
            if (acc && !rx_ok) m_rx_ovf = 1'b1;
        end
    end

    // Compare every cycle, mid-way between rising edges.
    always @(negedge clk) begin
        chk("pndng", 32'(pndng), 32'(txq.size() != 0));
        chk("D_pop", 32'(D_pop), 32'(txq.size() != 0 ? txq[0] : 16'h0));
        chk("tx_cnt", 32'(tx_cnt), 32'(txq.size()));
        chk("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
        chk("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
        chk("host_rdata", 32'(host_rdata), 32'(rxq.size() != 0 ? rxq[0] : 16'h0));
        chk("rx_cnt", 32'(rx_cnt), 32'(rxq.size()));
        chk("tx_ovf", 32'(tx_ovf), 32'(m_tx_ovf));
        chk("rx_ovf", 32'(rx_ovf), 32'(m_rx_ovf));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_pndng", 32'(pndng), 32'd0);
        chk("rst_D_pop", 32'(D_pop), 32'h0000);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_cnt", 32'(tx_cnt), 32'd0);
        chk("rst_rx_cnt", 32'(rx_cnt), 32'd0);
        chk("rst_ovf", 32'({tx_ovf, rx_ovf}), 32'd0);

        // TX ordering
        host_wr = 1'b1; host_wdata = 16'h00AA; cyc();
        chk("tx_first_pndng", 32'(pndng), 32'd1);
        chk("tx_first_D_pop", 32'(D_pop), 32'h00AA);
        host_wdata = 16'h02BB; cyc();
        host_wdata = 16'h03CC; cyc();
        host_wr = 1'b0;
        pop = 1'b1; cyc();
        chk("tx_pop1", 32'(D_pop), 32'h02BB);
        cyc();
        chk("tx_pop2", 32'(D_pop), 32'h03CC);
        cyc();
        chk("tx_empty_pndng", 32'(pndng), 32'd0);
        chk("tx_empty_D_pop", 32'(D_pop), 32'h0000);
        cyc();  // pop on empty: ignored
        chk("tx_pop_empty_cnt", 32'(tx_cnt), 32'd0);
        pop = 1'b0;

        // TX full / overflow
        host_wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            host_wdata = 16'h0100 + 16'(i);
            cyc();
        end
        host_wr = 1'b0;
        chk("tx_full", 32'(tx_full), 32'd1);
        chk("tx_cnt8", 32'(tx_cnt), 32'd8);
        chk("tx_ovf_set", 32'(tx_ovf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain", 32'(D_pop), 32'h0100 + 32'(i));
            pop = 1'b1; cyc(); pop = 1'b0;
        end
        chk("tx_drained", 32'(pndng), 32'd0);
        host_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_wdata = 16'h0200 + 16'(i);
            cyc();
        end
        host_wr = 1'b0;
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("tx_ovf_clr", 32'(tx_ovf), 32'd0);
        host_wr = 1'b1; pop = 1'b1; host_wdata = 16'h0208; cyc();
        host_wr = 1'b0; pop = 1'b0;
        chk("tx_wrpop_full_cnt", 32'(tx_cnt), 32'd8);
        chk("tx_wrpop_full_ovf", 32'(tx_ovf), 32'd0);
        chk("tx_wrpop_full_head", 32'(D_pop), 32'h0201);
        pop = 1'b1; repeat (8) cyc(); pop = 1'b0;
        chk("tx_empty_again", 32'(tx_cnt), 32'd0);

        // RX filter
        push = 1'b1;
        D_push = 16'h01AA; cyc();
        D_push = 16'h02BB; cyc();
        D_push = 16'hFFCC; cyc();
        push = 1'b0;
        chk("rx_filter_cnt", 32'(rx_cnt), 32'd2);
        chk("rx_filter_d0", 32'(host_rdata), 32'h01AA);
        host_rd = 1'b1; cyc();
        chk("rx_filter_d1", 32'(host_rdata), 32'hFFCC);
        cyc(); host_rd = 1'b0;
        chk("rx_filter_empty", 32'(rx_valid), 32'd0);

        // RX overflow and wrap
        push = 1'b1;
        for (int i = 0; i < 10; i++) begin
            D_push = 16'h0100 + 16'(i);
            cyc();
        end
        push = 1'b0;
        chk("rx_ovf_set", 32'(rx_ovf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("rx_drain", 32'(host_rdata), 32'h0100 + 32'(i));
            host_rd = 1'b1; cyc(); host_rd = 1'b0;
        end
        push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            D_push = 16'h0110 + 16'(i);
            cyc();
        end
        push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rx_wrap", 32'(host_rdata), 32'h0110 + 32'(i));
            host_rd = 1'b1; cyc(); host_rd = 1'b0;
        end
        chk("rx_wrap_empty", 32'(rx_cnt), 32'd0);
        // Set wins over clear
        push = 1'b1; D_push = 16'hFF00;
        repeat (8) cyc();
        ovf_clr = 1'b1; cyc();
        push = 1'b0; ovf_clr = 1'b0;
        chk("rx_ovf_set_wins", 32'(rx_ovf), 32'd1);
        host_rd = 1'b1; repeat (8) cyc(); host_rd = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            host_wr    = ($urandom_range(0, 1) == 1);
            host_wdata = 16'($urandom);
            pop        = ($urandom_range(0, 9) < 4);
            push       = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 3);
            D_push = 16'($urandom);
            if (r == 0) D_push[15:8] = 8'h01;
            else if (r == 1) D_push[15:8] = 8'hFF;
            host_rd = ($urandom_range(0, 9) < 4);
            ovf_clr = ($urandom_range(0, 19) == 0);
            cyc();
        end
        host_wr = 1'b0; pop = 1'b0; push = 1'b0; host_rd = 1'b0; ovf_clr = 1'b0;
        cyc();

        // Mid-operation reset
        pop = 1'b1; host_rd = 1'b1; repeat (8) cyc(); pop = 1'b0; host_rd = 1'b0;
        host_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_wdata = 16'h0300 + 16'(i);
            cyc();
        end
        host_wr = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 2; i++) begin
            D_push = 16'h0130 + 16'(i);
            cyc();
        end
        push = 1'b0;
        chk("pre_rst_tx_cnt", 32'(tx_cnt), 32'd3);
        chk("pre_rst_rx_cnt", 32'(rx_cnt), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pndng", 32'(pndng), 32'd0);
        chk("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("async_rst_tx_cnt", 32'(tx_cnt), 32'd0);
        chk("async_rst_rx_cnt", 32'(rx_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
